// File: rtl/demux_serial_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_serial_feeder_if : word/destination handshake plus serial demux feed
// Revision 1.0
// ---------------------------------------------------------------------------
interface demux_serial_feeder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_dest;
  logic             data_out;
  logic [2:0]       select;
  logic             frame_active;
  logic             frame_done;
  logic [7:0]       frames_sent;

  modport master (
    output in_valid, in_data, in_dest,
    input  in_ready, data_out, select, frame_active, frame_done, frames_sent
  );

  modport slave (
    input  in_valid, in_data, in_dest,
    output in_ready, data_out, select, frame_active, frame_done, frames_sent
  );
endinterface
`default_nettype wire

// File: rtl/demux_serial_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_serial_feeder : serializes a word MSB first toward one demux output
// Revision 1.0
// ---------------------------------------------------------------------------
module demux_serial_feeder #(
  parameter int WIDTH = 8
) (
  input  wire                    clk,
  input  wire                    rst,
  demux_serial_feeder_if.slave   bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       select_q, select_d;
  logic             data_out_q, data_out_d;
  logic             in_ready_q, in_ready_d;
  logic             frame_active_q, frame_active_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       frames_sent_q, frames_sent_d;

  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_d          = cnt_q;
    select_d       = select_q;
    data_out_d     = data_out_q;
    in_ready_d     = in_ready_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    frames_sent_d  = frames_sent_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d        = SHIFT;
          shreg_d        = bus.in_data;
          cnt_d          = CNT_W'(WIDTH - 1);
          select_d       = bus.in_dest;
          data_out_d     = bus.in_data[WIDTH-1];
          frame_active_d = 1'b1;
          in_ready_d     = 1'b0;
        end
      end
      SHIFT: begin
        // Outputs are registered, so the bit loaded here is the one shown next cycle.
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          state_d        = GAP;
          data_out_d     = 1'b0;
          frame_active_d = 1'b0;
          frame_done_d   = 1'b1;
          frames_sent_d  = frames_sent_q + 8'd1;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
          data_out_d = shreg_q[WIDTH-2];
        end
      end
      GAP: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      select_q       <= 3'd0;
      data_out_q     <= 1'b0;
      in_ready_q     <= 1'b1;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frames_sent_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      select_q       <= select_d;
      data_out_q     <= data_out_d;
      in_ready_q     <= in_ready_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      frames_sent_q  <= frames_sent_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.data_out     = data_out_q;
  assign bus.select       = select_q;
  assign bus.frame_active = frame_active_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frames_sent  = frames_sent_q;
endmodule
`default_nettype wire

// File: tb/tb_demux_serial_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_demux_serial_feeder : directed self-checking bench for demux_serial_feeder
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_demux_serial_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  demux_serial_feeder_if #(.WIDTH(8)) bus ();

  demux_serial_feeder #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_dest  = 3'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1 || bus.data_out !== 1'b0 || bus.select !== 3'd0 ||
          bus.frame_active !== 1'b0 || bus.frame_done !== 1'b0 || bus.frames_sent !== 8'd0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: got rdy=%b d=%b sel=%0d act=%b done=%b cnt=%0d expected 1 0 0 0 0 0",
                 i, bus.in_ready, bus.data_out, bus.select, bus.frame_active, bus.frame_done, bus.frames_sent);
      end
      tick();
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    w = 8'hA5;
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_dest  = 3'd3;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.data_out !== w[7-i] || bus.select !== 3'd3 || bus.frame_active !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL single_bit%0d: got d=%b sel=%0d act=%b rdy=%b expected d=%b sel=3 act=1 rdy=0",
                 i, bus.data_out, bus.select, bus.frame_active, bus.in_ready, w[7-i]);
      end
      tick();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.frames_sent !== 8'd1 || bus.data_out !== 1'b0 ||
        bus.frame_active !== 1'b0 || bus.in_ready !== 1'b0 || bus.select !== 3'd3) begin
      failures++;
      $display("FAIL single_gap: got done=%b cnt=%0d d=%b act=%b rdy=%b sel=%0d expected 1 1 0 0 0 3",
               bus.frame_done, bus.frames_sent, bus.data_out, bus.frame_active, bus.in_ready, bus.select);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.frame_done !== 1'b0 || bus.frames_sent !== 8'd1 ||
        bus.select !== 3'd3) begin
      failures++;
      $display("FAIL single_idle: got rdy=%b done=%b cnt=%0d sel=%0d expected 1 0 1 3",
               bus.in_ready, bus.frame_done, bus.frames_sent, bus.select);
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int waited;
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_dest  = 3'd7;
    tick();
    t1 = cyc;
    bus.in_data = 8'h01;
    bus.in_dest = 3'd0;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      checks++;
      if (bus.select !== 3'd7) begin
        failures++;
        $display("FAIL b2b_hold_sel: got %0d expected 7", bus.select);
      end
      tick();
      waited++;
    end
    checks++;
    if (bus.select !== 3'd7) begin
      failures++;
      $display("FAIL b2b_idle_sel: got %0d expected 7", bus.select);
    end
    tick();
    checks++;
    if (cyc - t1 !== 10) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d expected 10", cyc - t1);
    end
    checks++;
    if (bus.select !== 3'd0 || bus.data_out !== 1'b0 || bus.frame_active !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second_start: got sel=%0d d=%b act=%b expected 0 0 1",
               bus.select, bus.data_out, bus.frame_active);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.frame_done !== 1'b1 || bus.frames_sent !== 8'd2) begin
      failures++;
      $display("FAIL b2b_count: got done=%b cnt=%0d expected 1 2", bus.frame_done, bus.frames_sent);
    end
    tick();
  endtask

  task automatic test_input_change();
    logic [7:0] w;
    w = 8'h3C;
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_dest  = 3'd5;
    tick();
    bus.in_data = 8'hC3;
    bus.in_dest = 3'd2;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.data_out !== w[7-i] || bus.select !== 3'd5 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL change_bit%0d: got d=%b sel=%0d rdy=%b expected d=%b sel=5 rdy=0",
                 i, bus.data_out, bus.select, bus.in_ready, w[7-i]);
      end
      tick();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.in_ready !== 1'b0 || bus.select !== 3'd5) begin
      failures++;
      $display("FAIL change_gap: got done=%b rdy=%b sel=%0d expected 1 0 5",
               bus.frame_done, bus.in_ready, bus.select);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.select !== 3'd5) begin
      failures++;
      $display("FAIL change_idle: got rdy=%b sel=%0d expected 1 5", bus.in_ready, bus.select);
    end
    tick();
    checks++;
    if (bus.select !== 3'd2 || bus.data_out !== 1'b1 || bus.frame_active !== 1'b1) begin
      failures++;
      $display("FAIL change_new_accept: got sel=%0d d=%b act=%b expected 2 1 1",
               bus.select, bus.data_out, bus.frame_active);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_dest  = 3'd6;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.data_out !== 1'b0 || bus.select !== 3'd0 ||
        bus.frame_active !== 1'b0 || bus.frame_done !== 1'b0 || bus.frames_sent !== 8'd0) begin
      failures++;
      $display("FAIL midreset_values: got rdy=%b d=%b sel=%0d act=%b done=%b cnt=%0d expected 1 0 0 0 0 0",
               bus.in_ready, bus.data_out, bus.select, bus.frame_active, bus.frame_done, bus.frames_sent);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.frame_done !== 1'b0 || bus.frames_sent !== 8'd0 || bus.frame_active !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet cyc%0d: got done=%b cnt=%0d act=%b expected 0 0 0",
                 i, bus.frame_done, bus.frames_sent, bus.frame_active);
      end
    end
  endtask

  task automatic test_counter_wrap();
    int accepted;
    int pulses;
    logic [7:0] exp_cnt;
    apply_reset();
    accepted = 0;
    pulses   = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    bus.in_dest  = 3'd0;
    for (int c = 0; c < 256 * 10 + 40; c++) begin
      if (bus.frame_done === 1'b1) begin
        pulses++;
        exp_cnt = pulses[7:0];
        checks++;
        if (bus.frames_sent !== exp_cnt) begin
          failures++;
          $display("FAIL wrap_count pulse%0d: got %0d expected %0d", pulses, bus.frames_sent, exp_cnt);
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) accepted++;
      tick();
      if (accepted == 256) bus.in_valid = 1'b0;
      bus.in_data = accepted[7:0];
      bus.in_dest = accepted[2:0];
    end
    checks++;
    if (pulses !== 256) begin
      failures++;
      $display("FAIL wrap_pulses: got %0d expected 256", pulses);
    end
    checks++;
    if (bus.frames_sent !== 8'd0) begin
      failures++;
      $display("FAIL wrap_final: got %0d expected 0", bus.frames_sent);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_dest  = 3'd0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_input_change();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
